// File: rtl/wb_port_arbiter.sv
// GRF write-port arbiter: pipeline writes pass straight through, side-unit results
// wait in a small FIFO and fill idle write slots, with RAW/starvation stall requests.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_wd,
  input  logic        side_valid,
  input  logic [4:0]  side_addr,
  input  logic [31:0] side_wd,
  output logic        side_ready,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wd,
  output logic        stall_req,
  output logic        pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [AGE_W-1:0] age;

  logic pw;
  logic empty;
  logic head_valid;
  logic has_room;
  logic sacc;
  logic bypass;
  logic pop;
  logic push;
  logic hit;
  logic starve;

  // A squashed head is dropped every cycle; a valid head only loses to a pipeline write.
  always_comb begin
    pw         = pipe_we && (pipe_addr != 5'd0);
    empty      = (count == '0);
    head_valid = !empty && ent_valid[head];
    has_room   = (count < CNT_W'(DEPTH));
    side_ready = !reset && has_room;
    sacc       = side_valid && side_ready;
    bypass     = !pw && empty && sacc && (side_addr != 5'd0);
    pop        = !empty && (!ent_valid[head] || !pw);
    push       = sacc && !bypass && (side_addr != 5'd0) && !(pw && (side_addr == pipe_addr));
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_wd   = 32'd0;
    if (!reset) begin
      if (pw) begin
        rf_we   = 1'b1;
        rf_addr = pipe_addr;
        rf_wd   = pipe_wd;
      end else if (head_valid) begin
        rf_we   = 1'b1;
        rf_addr = ent_addr[head];
        rf_wd   = ent_data[head];
      end else if (bypass) begin
        rf_we   = 1'b1;
        rf_addr = side_addr;
        rf_wd   = side_wd;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] &&
          (((rd_addr1 != 5'd0) && (ent_addr[i] == rd_addr1)) ||
           ((rd_addr2 != 5'd0) && (ent_addr[i] == rd_addr2))))
        hit = 1'b1;
    end
    starve    = (age >= AGE_W'(STARVE_MAX));
    stall_req = !reset && (hit || starve);
    pending   = !reset && (|ent_valid);
  end

  // Payload storage needs no reset: validity lives in ent_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= side_addr;
      ent_data[tail] <= side_wd;
    end
  end

  // A pipeline write is younger than anything queued, so it kills queued writes to the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      age       <= '0;
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pw && (ent_addr[i] == pipe_addr))
          ent_valid[i] <= 1'b0;
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop || empty)
        age <= '0;
      else if (head_valid && (age < AGE_W'(STARVE_MAX)))
        age <= age + AGE_W'(1);
    end
  end

endmodule
